// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sweep host.
//   OPERAND_W / RESULT_W : calculator operand and result widths
//   IDX_W                : width of the packed (a,b) pair index
//   sweep_state_t        : sequencer FSM states
//   CRC8_POLY            : CRC-8 polynomial used by the signature accumulator
//   crc8_byte()          : one-byte CRC-8 update, MSB first, no reflection
package calc_pkg;

  localparam int OPERAND_W = 4;
  localparam int RESULT_W  = 8;
  localparam int IDX_W     = 2 * OPERAND_W;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } sweep_state_t;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/calc_sig_accum.sv
// Run-signature register for the sweep host.
// Build option: CALC_SWEEP_CRC_EN
//   defined   -> signature is CRC-8 (poly 0x07, init 0, no reflection, no final XOR)
//   undefined -> signature is the modulo-256 sum of the accepted bytes
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears signature)
//   clr_i     : clear signature to 0 (takes priority over en_i)
//   en_i      : fold data_i into the signature this cycle
//   data_i    : byte to fold in
//   sig_o     : current signature
module calc_sig_accum
  import calc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [RESULT_W-1:0] data_i,
  output logic [RESULT_W-1:0] sig_o
);

  logic [RESULT_W-1:0] sig_q;
  logic [RESULT_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
`ifdef CALC_SWEEP_CRC_EN
      sig_d = crc8_byte(sig_q, data_i);
`else
      sig_d = sig_q + data_i;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/calc_sweep_host.sv
// Host-side sequencer that sweeps every (a,b) operand pair through a
// 4-bit/8-bit calculator, captures each result after LATENCY cycles and
// streams it out on a valid/ready interface while building a run signature.
// Build option: CALC_SWEEP_CRC_EN (selects CRC-8 vs. sum signature, see
// calc_sig_accum).
// Parameters:
//   LATENCY   : cycles from operands driven to result_in sampled (1..7)
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a sweep (only honoured in IDLE)
//   busy, done          : sweep in progress / one-cycle end-of-sweep pulse
//   a_out, b_out        : operands to the calculator
//   result_in           : calculator result
//   res_valid/res_ready : output stream handshake
//   res_data, res_a/b   : captured result and the operands that produced it
//   res_last            : marks the (15,15) pair
//   signature           : running signature of transferred results
module calc_sweep_host
  import calc_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [OPERAND_W-1:0] a_out,
  output logic [OPERAND_W-1:0] b_out,
  input  logic [RESULT_W-1:0]  result_in,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RESULT_W-1:0]  res_data,
  output logic [OPERAND_W-1:0] res_a,
  output logic [OPERAND_W-1:0] res_b,
  output logic                 res_last,
  output logic [RESULT_W-1:0]  signature
);

  // DRIVE ends on the cycle where the wait counter reaches LATENCY-1.
  localparam logic [2:0] LAST_CNT = 3'(LATENCY - 1);

  sweep_state_t        state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [RESULT_W-1:0] res_data_q, res_data_d;
  logic [IDX_W-1:0]    res_idx_q, res_idx_d;
  logic                sig_clr;
  logic                sig_en;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_idx_d  = res_idx_q;
    sig_clr    = 1'b0;
    sig_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          cnt_d   = '0;
          sig_clr = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == LAST_CNT) begin
          res_data_d = result_in;
          res_idx_d  = idx_q;
          state_d    = ST_PRESENT;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_PRESENT: begin
        if (res_ready) begin
          sig_en = 1'b1;
          // The transfer of pair 0xFF ends the sweep; idx never wraps.
          if (idx_q == {IDX_W{1'b1}}) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            cnt_d   = '0;
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_idx_q  <= res_idx_d;
    end
  end

  calc_sig_accum u_sig (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (sig_clr),
    .en_i   (sig_en),
    .data_i (res_data_q),
    .sig_o  (signature)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign a_out     = idx_q[IDX_W-1:OPERAND_W];
  assign b_out     = idx_q[OPERAND_W-1:0];
  assign res_valid = (state_q == ST_PRESENT);
  assign res_data  = res_data_q;
  assign res_a     = res_idx_q[IDX_W-1:OPERAND_W];
  assign res_b     = res_idx_q[OPERAND_W-1:0];
  assign res_last  = res_valid && (res_idx_q == {IDX_W{1'b1}});

endmodule

// File: tb/tb_calc_sweep_host.sv
// Testbench for calc_sweep_host: two instances (LATENCY=1 and LATENCY=3),
// each fed by a calculator stub whose result is ready at the LATENCY-th
// edge after the operands change. Table of full sweeps plus hand-written
// reset-in-PRESENT sequence.
module tb_calc_sweep_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       add_sel;
  logic       start [2];
  logic       ready [2];
  logic       busy  [2];
  logic       done  [2];
  logic       valid [2];
  logic       last  [2];
  logic [3:0] a     [2];
  logic [3:0] b     [2];
  logic [3:0] ra    [2];
  logic [3:0] rb    [2];
  logic [7:0] rin   [2];
  logic [7:0] rdata [2];
  logic [7:0] sig   [2];
  logic [7:0] pipe3 [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] calc_f(input logic [3:0] x, input logic [3:0] y, input logic add);
    return add ? ({4'd0, x} + {4'd0, y}) : {x, y};
  endfunction

  // Stubs: LATENCY=1 result is valid before the first sampling edge;
  // LATENCY=3 result passes two registers.
  assign rin[0] = calc_f(a[0], b[0], add_sel);
  always @(posedge clk) begin
    pipe3[0] <= calc_f(a[1], b[1], add_sel);
    pipe3[1] <= pipe3[0];
  end
  assign rin[1] = pipe3[1];

  calc_sweep_host #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .a_out(a[0]), .b_out(b[0]), .result_in(rin[0]), .res_valid(valid[0]),
    .res_ready(ready[0]), .res_data(rdata[0]), .res_a(ra[0]), .res_b(rb[0]),
    .res_last(last[0]), .signature(sig[0])
  );

  calc_sweep_host #(.LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .a_out(a[1]), .b_out(b[1]), .result_in(rin[1]), .res_valid(valid[1]),
    .res_ready(ready[1]), .res_data(rdata[1]), .res_a(ra[1]), .res_b(rb[1]),
    .res_last(last[1]), .signature(sig[1])
  );

  // Bit-serial CRC-8/0x07 reference.
  function automatic logic [7:0] crc_ref(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] r;
    logic fb;
    r = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  function automatic logic [7:0] sig_step(input logic [7:0] s, input logic [7:0] d);
`ifdef CALC_SWEEP_CRC_EN
    return crc_ref(s, d);
`else
    return s + d;
`endif
  endfunction

  function automatic logic [7:0] exp_sig_of(input logic add);
`ifdef CALC_SWEEP_CRC_EN
    logic [7:0] s;
    logic [7:0] n8;
    s = 8'h00;
    for (int n = 0; n < 256; n++) begin
      n8 = 8'(n);
      s  = crc_ref(s, calc_f(n8[7:4], n8[3:0], add));
    end
    return s;
`else
    return add ? 8'h00 : 8'h80;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input int k, input string tag);
    chk({tag, " busy"},      int'(busy[k]),  0);
    chk({tag, " done"},      int'(done[k]),  0);
    chk({tag, " a_out"},     int'(a[k]),     0);
    chk({tag, " b_out"},     int'(b[k]),     0);
    chk({tag, " res_valid"}, int'(valid[k]), 0);
    chk({tag, " res_data"},  int'(rdata[k]), 0);
    chk({tag, " res_a"},     int'(ra[k]),    0);
    chk({tag, " res_b"},     int'(rb[k]),    0);
    chk({tag, " res_last"},  int'(last[k]),  0);
    chk({tag, " signature"}, int'(sig[k]),   0);
  endtask

  // One full sweep on instance k. Inputs change and outputs are sampled on
  // the falling edge; c counts falling edges after the start edge.
  task automatic run_sweep(input int k, input bit add, input bit stall, input bit poke,
                           input int exp_done, input logic [7:0] exp_sig, input string tag);
    int n, c, done_cnt, done_at;
    bit prev_stall;
    logic [7:0] hold_d, exp_b, model, n8;
    logic [3:0] hold_a, hold_b;
    n = 0; c = 0; done_cnt = 0; done_at = 0; prev_stall = 0; model = 8'h00;
    hold_d = 0; hold_a = 0; hold_b = 0;
    @(negedge clk);
    add_sel  = add;
    ready[k] = 1'b1;
    start[k] = 1'b1;
    @(posedge clk);
    while (c < 4000 && !(done_cnt > 0 && c >= done_at + 3)) begin
      @(negedge clk);
      c++;
      start[k] = poke && (n < 255) && ($urandom_range(0, 3) == 0);
      if (c == 1) begin
        chk({tag, " busy after start"}, int'(busy[k]), 1);
        chk({tag, " first operands"},   int'({a[k], b[k]}), 0);
        chk({tag, " signature cleared"}, int'(sig[k]), 0);
      end
      chk({tag, " res_last"}, int'(last[k]), int'(valid[k] && ra[k] == 4'hF && rb[k] == 4'hF));
      if (prev_stall) begin
        chk({tag, " valid held"},    int'(valid[k]), 1);
        chk({tag, " data held"},     int'(rdata[k]), int'(hold_d));
        chk({tag, " operands held"}, int'({ra[k], rb[k]}), int'({hold_a, hold_b}));
      end
      if (done[k]) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at = c;
          chk({tag, " done after 256 transfers"}, n, 256);
        end
      end
      if (done_cnt > 0 && c == done_at + 1)
        chk({tag, " busy low after done"}, int'(busy[k]), 0);
      prev_stall = 0;
      ready[k] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid[k]) begin
        if (ready[k]) begin
          if (n > 255) begin
            chk({tag, " extra transfer"}, n, 255);
          end else begin
            n8    = 8'(n);
            exp_b = calc_f(n8[7:4], n8[3:0], add);
            chk({tag, " res_data"}, int'(rdata[k]), int'(exp_b));
            chk({tag, " res_a/res_b"}, int'({ra[k], rb[k]}), n);
            if (n == 255)
              chk({tag, " pair 15,15 data"}, int'(rdata[k]), add ? 8'h1E : 8'hFF);
            model = sig_step(model, exp_b);
          end
          n++;
        end else begin
          prev_stall = 1;
          hold_d = rdata[k]; hold_a = ra[k]; hold_b = rb[k];
        end
      end
    end
    start[k] = 1'b0;
    chk({tag, " done pulses"}, done_cnt, 1);
    chk({tag, " transfers"}, n, 256);
    if (exp_done != 0) chk({tag, " done cycle"}, done_at, exp_done);
    chk({tag, " signature"}, int'(sig[k]), int'(exp_sig));
    chk({tag, " signature model"}, int'(sig[k]), int'(model));
    chk({tag, " idle busy"}, int'(busy[k]), 0);
    $display("sweep %s: transfers=%0d done_at=%0d signature=0x%02h", tag, n, done_at, sig[k]);
  endtask

  typedef struct {
    int         k;
    bit         add;
    bit         stall;
    bit         poke;
    int         exp_done;
    logic [7:0] exp_sig;
    string      tag;
  } sweep_vec_t;

  sweep_vec_t vecs [5];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int  k;
    bit  found;
    vecs[0] = '{0, 1'b0, 1'b0, 1'b0,  513, exp_sig_of(1'b0), "L1 concat"};
    vecs[1] = '{0, 1'b1, 1'b0, 1'b0,  513, exp_sig_of(1'b1), "L1 add"};
    vecs[2] = '{1, 1'b0, 1'b1, 1'b0,    0, exp_sig_of(1'b0), "L3 backpressure"};
    vecs[3] = '{1, 1'b0, 1'b0, 1'b0, 1025, exp_sig_of(1'b0), "L3 nostall"};
    vecs[4] = '{0, 1'b0, 1'b0, 1'b1,  513, exp_sig_of(1'b0), "L1 start pokes"};

    rst = 1'b1; add_sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset(0, "por L1");
    chk_reset(1, "por L3");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_sweep(vecs[i].k, vecs[i].add, vecs[i].stall, vecs[i].poke,
                vecs[i].exp_done, vecs[i].exp_sig, vecs[i].tag);
    end

    // Reset while pair 0x42 is being presented and stalled.
    k = 0;
    @(negedge clk);
    add_sel = 1'b0; ready[k] = 1'b1; start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    found = 0;
    for (int c = 0; c < 1000 && !found; c++) begin
      if (valid[k] && ra[k] == 4'h4 && rb[k] == 4'h2) begin
        ready[k] = 1'b0;
        found = 1;
      end else begin
        ready[k] = 1'b1;
        @(negedge clk);
      end
    end
    chk("reach pair 0x42", int'(found), 1);
    @(negedge clk);
    chk("stalled at 0x42", int'({valid[k], ra[k], rb[k]}), 9'h142);
    rst = 1'b1;
    @(negedge clk);
    chk_reset(k, "mid-sweep reset");
    rst = 1'b0;
    ready[k] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no done after reset", int'(done[k]), 0);
      chk("idle after reset", int'(busy[k]), 0);
    end
    $display("reset at pair 0x42: outputs cleared");
    run_sweep(0, 1'b0, 1'b0, 1'b0, 513, exp_sig_of(1'b0), "L1 after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
